// File: rtl/red_pitaya_sys_pkg.sv
// Shared types and helpers for the two-master system-bus arbiter.
package red_pitaya_sys_pkg;

  localparam int NUM_MASTERS = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        we;
  } sys_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ack;
    logic        err;
  } sys_rsp_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  // Completion forced onto a master when the slave stays silent.
  function automatic sys_rsp_t timeout_rsp(input logic [31:0] rderr);
    sys_rsp_t r;
    r.rdata = rderr;
    r.ack   = 1'b1;
    r.err   = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/red_pitaya_sys_req_latch.sv
// Per-master front end: captures a one-cycle strobe, tracks busy/pending and
// drives the registered one-cycle completion back to the master.
module red_pitaya_sys_req_latch
  import red_pitaya_sys_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  sel,
  input  logic        wen,
  input  logic        ren,
  input  logic        grant,
  input  logic        done,
  input  logic        rsp_load,
  input  logic [31:0] rsp_rdata,
  input  logic        rsp_ack,
  input  logic        rsp_err,
  output logic        pending,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_sel,
  output logic        req_we,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err
);

  logic        busy_reg;
  logic        pending_reg;
  sys_req_t    req_reg;
  logic [31:0] rdata_reg;
  logic        ack_reg;
  logic        err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg    <= 1'b0;
      pending_reg <= 1'b0;
      req_reg     <= '0;
      rdata_reg   <= '0;
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      // A strobe while busy is dropped; grant/done only ever apply while busy.
      if ((wen || ren) && !busy_reg) begin
        busy_reg      <= 1'b1;
        pending_reg   <= 1'b1;
        req_reg.addr  <= addr;
        req_reg.wdata <= wdata;
        req_reg.sel   <= sel;
        req_reg.we    <= wen;
      end else begin
        if (grant) pending_reg <= 1'b0;
        if (done)  busy_reg    <= 1'b0;
      end
      ack_reg   <= rsp_load & rsp_ack;
      err_reg   <= rsp_load & rsp_err;
      rdata_reg <= rsp_load ? rsp_rdata : 32'h0;
    end
  end

  assign pending   = pending_reg;
  assign req_addr  = req_reg.addr;
  assign req_wdata = req_reg.wdata;
  assign req_sel   = req_reg.sel;
  assign req_we    = req_reg.we;
  assign rdata     = rdata_reg;
  assign ack       = ack_reg;
  assign err       = err_reg;

endmodule

// File: rtl/red_pitaya_sys_arb.sv
// Round-robin arbiter giving two bus masters shared access to the housekeeping
// register slave, with a timeout that completes accesses to a silent slave.
module red_pitaya_sys_arb
  import red_pitaya_sys_pkg::*;
#(
  parameter logic [7:0]  TMO   = 8'd32,
  parameter logic [31:0] RDERR = 32'h0
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_wen_i,
  input  logic        m0_ren_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_wen_i,
  input  logic        m1_ren_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] sys_addr_o,
  output logic [31:0] sys_wdata_o,
  output logic [3:0]  sys_sel_o,
  output logic        sys_wen_o,
  output logic        sys_ren_o,
  input  logic [31:0] sys_rdata_i,
  input  logic        sys_ack_i,
  input  logic        sys_err_i,
  output logic [1:0]  grant_o
);

  logic [31:0] m_addr    [NUM_MASTERS];
  logic [31:0] m_wdata   [NUM_MASTERS];
  logic [3:0]  m_sel     [NUM_MASTERS];
  logic [31:0] m_rdata   [NUM_MASTERS];
  logic [31:0] req_addr  [NUM_MASTERS];
  logic [31:0] req_wdata [NUM_MASTERS];
  logic [3:0]  req_sel   [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] m_wen, m_ren, m_ack, m_err;
  logic [NUM_MASTERS-1:0] pending, req_we, grant_clr, rsp_load, done;

  assign m_addr[0]  = m0_addr_i;
  assign m_addr[1]  = m1_addr_i;
  assign m_wdata[0] = m0_wdata_i;
  assign m_wdata[1] = m1_wdata_i;
  assign m_sel[0]   = m0_sel_i;
  assign m_sel[1]   = m1_sel_i;
  assign m_wen      = {m1_wen_i, m0_wen_i};
  assign m_ren      = {m1_ren_i, m0_ren_i};

  arb_state_t state_reg, state_next;
  logic       owner_reg;
  logic       rr_reg;
  logic       pick;
  logic [7:0] cnt_reg;
  logic [1:0] grant_reg;
  sys_req_t   sys_req_reg;
  logic       strobe_reg;
  sys_rsp_t   rsp;
  logic       slave_done;

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      red_pitaya_sys_req_latch u_latch (
        .clk       (clk_i),
        .rst_n     (rstn_i),
        .addr      (m_addr[gi]),
        .wdata     (m_wdata[gi]),
        .sel       (m_sel[gi]),
        .wen       (m_wen[gi]),
        .ren       (m_ren[gi]),
        .grant     (grant_clr[gi]),
        .done      (done[gi]),
        .rsp_load  (rsp_load[gi]),
        .rsp_rdata (rsp.rdata),
        .rsp_ack   (rsp.ack),
        .rsp_err   (rsp.err),
        .pending   (pending[gi]),
        .req_addr  (req_addr[gi]),
        .req_wdata (req_wdata[gi]),
        .req_sel   (req_sel[gi]),
        .req_we    (req_we[gi]),
        .rdata     (m_rdata[gi]),
        .ack       (m_ack[gi]),
        .err       (m_err[gi])
      );
    end
  endgenerate

  assign m0_rdata_o = m_rdata[0];
  assign m1_rdata_o = m_rdata[1];
  assign m0_ack_o   = m_ack[0];
  assign m1_ack_o   = m_ack[1];
  assign m0_err_o   = m_err[0];
  assign m1_err_o   = m_err[1];

  assign slave_done = sys_ack_i | sys_err_i;

  always_comb begin
    state_next = state_reg;
    pick       = owner_reg;
    grant_clr  = '0;
    rsp_load   = '0;
    done       = '0;
    if (slave_done) begin
      rsp.rdata = sys_rdata_i;
      rsp.ack   = sys_ack_i;
      rsp.err   = sys_err_i;
    end else begin
      rsp = timeout_rsp(RDERR);
    end
    case (state_reg)
      IDLE: begin
        if (|pending) begin
          // On a tie the master that did not win last time goes first.
          pick            = (&pending) ? ~rr_reg : pending[1];
          grant_clr[pick] = 1'b1;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        if (slave_done) begin
          rsp_load[owner_reg] = 1'b1;
          state_next          = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (slave_done || cnt_reg == TMO - 8'd1) begin
          rsp_load[owner_reg] = 1'b1;
          state_next          = RESP;
        end
      end
      RESP: begin
        done[owner_reg] = 1'b1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg   <= IDLE;
      owner_reg   <= 1'b0;
      rr_reg      <= 1'b1;
      cnt_reg     <= 8'd0;
      grant_reg   <= 2'b00;
      sys_req_reg <= '0;
      strobe_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      strobe_reg <= 1'b0;
      if (state_reg == IDLE && state_next == ISSUE) begin
        owner_reg         <= pick;
        rr_reg            <= pick;
        grant_reg         <= pick ? 2'b10 : 2'b01;
        sys_req_reg.addr  <= req_addr[pick];
        sys_req_reg.wdata <= req_wdata[pick];
        sys_req_reg.sel   <= req_sel[pick];
        sys_req_reg.we    <= req_we[pick];
        strobe_reg        <= 1'b1;
      end else if (state_reg == RESP) begin
        grant_reg <= 2'b00;
      end
      // The timeout window spans ISSUE plus WAIT.
      cnt_reg <= (state_reg == ISSUE || state_reg == WAIT) ? cnt_reg + 8'd1 : 8'd0;
    end
  end

  assign sys_addr_o  = sys_req_reg.addr;
  assign sys_wdata_o = sys_req_reg.wdata;
  assign sys_sel_o   = sys_req_reg.sel;
  assign sys_wen_o   = strobe_reg & sys_req_reg.we;
  assign sys_ren_o   = strobe_reg & ~sys_req_reg.we;
  assign grant_o     = grant_reg;

endmodule

// File: tb/tb_red_pitaya_sys_arb.sv
// Scoreboard bench for the two-master arbiter: expected slave strobes and
// master completions are queued at stimulus time and matched as they appear.
module tb_red_pitaya_sys_arb;

  localparam logic [7:0]  TMO   = 8'd32;
  localparam logic [31:0] RDERR = 32'h0;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_wen_i, m0_ren_i, m1_wen_i, m1_ren_i;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] sys_addr_o, sys_wdata_o, sys_rdata_i;
  logic [3:0]  sys_sel_o;
  logic        sys_wen_o, sys_ren_o, sys_ack_i, sys_err_i;
  logic [1:0]  grant_o;

  always #5 clk = ~clk;

  red_pitaya_sys_arb #(.TMO(TMO), .RDERR(RDERR)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_sel_i(m0_sel_i),
    .m0_wen_i(m0_wen_i), .m0_ren_i(m0_ren_i),
    .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_sel_i(m1_sel_i),
    .m1_wen_i(m1_wen_i), .m1_ren_i(m1_ren_i),
    .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .sys_addr_o(sys_addr_o), .sys_wdata_o(sys_wdata_o), .sys_sel_o(sys_sel_o),
    .sys_wen_o(sys_wen_o), .sys_ren_o(sys_ren_o),
    .sys_rdata_i(sys_rdata_i), .sys_ack_i(sys_ack_i), .sys_err_i(sys_err_i),
    .grant_o(grant_o)
  );

  typedef struct {
    int          m;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    int          cyc;
  } rsp_exp_t;

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } sys_exp_t;

  rsp_exp_t rsp_q[$];
  sys_exp_t sys_q[$];
  rsp_exp_t mon_rsp;
  sys_exp_t mon_sys;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   slave_delay = 1;
  logic slave_err = 1'b0;
  int   tb_rr = 1;
  int   sys_ren_cnt = 0;
  logic [31:0] slv_addr;
  int   slv_d;
  int   got_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: answers each strobe slave_delay cycles later with addr+1.
  always begin
    @(negedge clk);
    if (rstn_i === 1'b1 && (sys_wen_o || sys_ren_o) && slave_delay > 0) begin
      slv_addr = sys_addr_o;
      slv_d    = slave_delay;
      repeat (slv_d) @(posedge clk);
      #1;
      sys_rdata_i = slv_addr + 32'd1;
      sys_ack_i   = !slave_err;
      sys_err_i   = slave_err;
      @(posedge clk);
      #1;
      sys_ack_i   = 1'b0;
      sys_err_i   = 1'b0;
      sys_rdata_i = 32'hDEAD_BEEF;
    end
  end

  // Monitor: compares every slave strobe and master completion with the queues.
  always @(negedge clk) begin
    if (sys_wen_o || sys_ren_o) begin
      if (sys_ren_o) sys_ren_cnt++;
      $display("[%0d] sys strobe we=%0d addr=%08h wdata=%08h sel=%0h grant=%0b",
               cyc, sys_wen_o, sys_addr_o, sys_wdata_o, sys_sel_o, grant_o);
      if (sys_q.size() == 0) begin
        check("unexpected_sys_strobe", 64'({sys_wen_o, sys_ren_o}), 64'd0);
      end else begin
        mon_sys = sys_q.pop_front();
        check("sys_strobe", 64'({sys_wen_o, sys_ren_o}), mon_sys.we ? 64'd2 : 64'd1);
        check("sys_addr", 64'(sys_addr_o), 64'(mon_sys.addr));
        check("sys_sel", 64'(sys_sel_o), 64'(mon_sys.sel));
        if (mon_sys.we) check("sys_wdata", 64'(sys_wdata_o), 64'(mon_sys.wdata));
        check("sys_grant", 64'(grant_o), (mon_sys.m == 1) ? 64'd2 : 64'd1);
      end
    end
    if (m0_ack_o || m0_err_o || m1_ack_o || m1_err_o) begin
      got_m = (m1_ack_o || m1_err_o) ? 1 : 0;
      $display("[%0d] m%0d rsp rdata=%08h ack=%0d err=%0d", cyc, got_m,
               got_m ? m1_rdata_o : m0_rdata_o,
               got_m ? m1_ack_o : m0_ack_o, got_m ? m1_err_o : m0_err_o);
      if (rsp_q.size() == 0) begin
        check("unexpected_rsp", 64'({m1_ack_o, m1_err_o, m0_ack_o, m0_err_o}), 64'd0);
      end else begin
        mon_rsp = rsp_q.pop_front();
        check("rsp_master", 64'(got_m), 64'(mon_rsp.m));
        if (mon_rsp.m == 0) begin
          check("m0_rdata", 64'(m0_rdata_o), 64'(mon_rsp.rdata));
          check("m0_ack_err", 64'({m0_ack_o, m0_err_o}), 64'({mon_rsp.ack, mon_rsp.err}));
          check("m1_quiet", 64'({m1_ack_o, m1_err_o, m1_rdata_o}), 64'd0);
        end else begin
          check("m1_rdata", 64'(m1_rdata_o), 64'(mon_rsp.rdata));
          check("m1_ack_err", 64'({m1_ack_o, m1_err_o}), 64'({mon_rsp.ack, mon_rsp.err}));
          check("m0_quiet", 64'({m0_ack_o, m0_err_o, m0_rdata_o}), 64'd0);
        end
        check("rsp_grant", 64'(grant_o), (mon_rsp.m == 1) ? 64'd2 : 64'd1);
        if (mon_rsp.cyc >= 0) check("rsp_cycle", 64'(cyc), 64'(mon_rsp.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (m == 0) begin
      m0_wen_i = we; m0_ren_i = re; m0_addr_i = a; m0_wdata_i = d; m0_sel_i = s;
    end else begin
      m1_wen_i = we; m1_ren_i = re; m1_addr_i = a; m1_wdata_i = d; m1_sel_i = s;
    end
  endtask

  task automatic idle_strobes();
    m0_wen_i = 1'b0; m0_ren_i = 1'b0; m1_wen_i = 1'b0; m1_ren_i = 1'b0;
    m0_addr_i = 32'hFFFF_FFFF; m1_addr_i = 32'hFFFF_FFFF;
  endtask

  task automatic expect_acc(input int m, input logic we, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [31:0] rd, input logic ack,
                            input logic err, input int c);
    sys_exp_t se;
    rsp_exp_t re;
    se.m = m; se.we = we; se.addr = a; se.wdata = d; se.sel = s;
    re.m = m; re.rdata = rd; re.ack = ack; re.err = err; re.cyc = c;
    sys_q.push_back(se);
    rsp_q.push_back(re);
    tb_rr = m;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((rsp_q.size() != 0 || sys_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(rsp_q.size() + sys_q.size()), 64'd0);
    repeat (3) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 64'(grant_o), 64'd0);
    check({tag, "_sys_strobe"}, 64'({sys_wen_o, sys_ren_o}), 64'd0);
    check({tag, "_m_rsp"}, 64'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 64'd0);
    check({tag, "_m_rdata"}, 64'(m0_rdata_o | m1_rdata_o), 64'd0);
  endtask

  // Both masters strobe together; the loser of the last grant goes first.
  task automatic tie_pair();
    int first;
    int n;
    n = cyc;
    first = 1 - tb_rr;
    drive(0, 1'b1, 1'b0, 32'h30, 32'hA5, 4'hF);
    drive(1, 1'b0, 1'b1, 32'h04, 32'h0, 4'h3);
    if (first == 0) begin
      expect_acc(0, 1'b1, 32'h30, 32'hA5, 4'hF, 32'h31, 1'b1, 1'b0, n + 4);
      expect_acc(1, 1'b0, 32'h04, 32'h0, 4'h3, 32'h05, 1'b1, 1'b0, n + 8);
    end else begin
      expect_acc(1, 1'b0, 32'h04, 32'h0, 4'h3, 32'h05, 1'b1, 1'b0, n + 4);
      expect_acc(0, 1'b1, 32'h30, 32'hA5, 4'hF, 32'h31, 1'b1, 1'b0, n + 8);
    end
    tick();
    idle_strobes();
    drain(60);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ren_before;
    rstn_i = 1'b0;
    sys_ack_i = 1'b0; sys_err_i = 1'b0; sys_rdata_i = 32'hDEAD_BEEF;
    m0_wdata_i = '0; m1_wdata_i = '0; m0_sel_i = '0; m1_sel_i = '0;
    idle_strobes();
    repeat (3) tick();
    @(negedge clk);
    check_all_zero("reset");
    check("reset_sys_addr", 64'(sys_addr_o), 64'd0);
    tick();
    rstn_i = 1'b1;
    repeat (2) tick();

    // Tie right after reset: m0 first.
    tie_pair();

    // m0 read alone, then m0 again the cycle after its ack.
    n = cyc;
    drive(0, 1'b0, 1'b1, 32'h00, 32'h0, 4'hF);
    expect_acc(0, 1'b0, 32'h00, 32'h0, 4'hF, 32'h1, 1'b1, 1'b0, n + 4);
    tick(); idle_strobes();
    repeat (4) tick();
    drive(0, 1'b0, 1'b1, 32'h08, 32'h0, 4'hF);
    expect_acc(0, 1'b0, 32'h08, 32'h0, 4'hF, 32'h9, 1'b1, 1'b0, n + 9);
    tick(); idle_strobes();
    drain(40);

    // Tie again with m0 served last: m1 first.
    tie_pair();

    // Silent slave: forced completion, then a late ack must be ignored.
    slave_delay = 37;
    n = cyc;
    drive(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'hF);
    expect_acc(0, 1'b0, 32'h10, 32'h0, 4'hF, RDERR, 1'b1, 1'b1, n + 2 + int'(TMO));
    tick(); idle_strobes();
    drain(60);
    repeat (12) tick();
    slave_delay = 1;

    // m1 strobes while busy: dropped, one slave read, one ack.
    ren_before = sys_ren_cnt;
    n = cyc;
    drive(1, 1'b0, 1'b1, 32'h20, 32'h0, 4'hF);
    expect_acc(1, 1'b0, 32'h20, 32'h0, 4'hF, 32'h21, 1'b1, 1'b0, n + 4);
    tick();
    drive(1, 1'b0, 1'b1, 32'h24, 32'h0, 4'hF);
    tick(); idle_strobes();
    tick();
    drive(1, 1'b1, 1'b0, 32'h28, 32'h77, 4'hF);
    tick(); idle_strobes();
    drain(40);
    check("busy_single_ren", 64'(sys_ren_cnt - ren_before), 64'd1);

    // Slave error on an m1 write (wen and ren together count as a write).
    slave_err = 1'b1;
    n = cyc;
    drive(1, 1'b1, 1'b1, 32'h40, 32'h55, 4'h1);
    expect_acc(1, 1'b1, 32'h40, 32'h55, 4'h1, 32'h41, 1'b0, 1'b1, n + 4);
    tick(); idle_strobes();
    drain(40);
    slave_err = 1'b0;

    // Non-owner strobes during the owner's response cycle.
    n = cyc;
    drive(0, 1'b0, 1'b1, 32'h60, 32'h0, 4'hF);
    expect_acc(0, 1'b0, 32'h60, 32'h0, 4'hF, 32'h61, 1'b1, 1'b0, n + 4);
    tick(); idle_strobes();
    repeat (3) tick();
    drive(1, 1'b0, 1'b1, 32'h64, 32'h0, 4'h2);
    expect_acc(1, 1'b0, 32'h64, 32'h0, 4'h2, 32'h65, 1'b1, 1'b0, n + 8);
    tick(); idle_strobes();
    drain(40);

    // Reset while the access waits on a silent slave.
    slave_delay = 0;
    begin
      sys_exp_t se;
      se.m = 0; se.we = 1'b0; se.addr = 32'h50; se.wdata = 32'h0; se.sel = 4'hF;
      sys_q.push_back(se);
    end
    drive(0, 1'b0, 1'b1, 32'h50, 32'h0, 4'hF);
    tick(); idle_strobes();
    repeat (4) tick();
    rstn_i = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    check("midreset_sys_addr", 64'(sys_addr_o), 64'd0);
    tick(); tick();
    rstn_i = 1'b1;
    tb_rr = 1;
    slave_delay = 1;
    repeat (40) tick();
    @(negedge clk);
    check_all_zero("post_reset");
    check("post_reset_queues", 64'(rsp_q.size() + sys_q.size()), 64'd0);
    tick();

    // Pointer is back at its reset value: m0 wins the tie again.
    tie_pair();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
